cache_axi_txn_limiter: RTL



---
 rtl/cache_axi_txn_limiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cache_axi_txn_limiter.sv
// Outstanding-transaction limiter between the cache AXI master port and the interconnect.
// Optional stall-cycle counter enabled by defining CACHE_AXI_LIMITER_STALL_CNT_EN.

package ariane_axi;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module cache_axi_txn_limiter #(
  parameter int unsigned MaxRdTxn = 8,
  parameter int unsigned MaxWrTxn = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  ariane_axi::req_t  slv_req_i,
  output ariane_axi::resp_t slv_resp_o,
  output ariane_axi::req_t  mst_req_o,
  input  ariane_axi::resp_t mst_resp_i,
  input  logic              drain_i,
  output logic              idle_o,
  output logic [7:0]        rd_cnt_o,
  output logic [7:0]        wr_cnt_o,
  output logic              err_o,
  output logic [31:0]       stall_cnt_o
);

  logic [7:0] r_rd_cnt, r_wr_cnt, r_w_pend;
  logic       r_err, r_idle;
  logic [7:0] w_rd_nxt, w_wr_nxt, w_pend_nxt;
  logic       w_rd_full, w_wr_full, w_ar_open, w_aw_open, w_w_open;
  logic       w_ar_hs, w_aw_hs, w_w_hs, w_w_done, w_r_done, w_b_done, w_err_evt;

  assign w_rd_full = (r_rd_cnt == 8'(MaxRdTxn));
  assign w_wr_full = (r_wr_cnt == 8'(MaxWrTxn));
  assign w_ar_open = ~w_rd_full & ~drain_i;
  assign w_aw_open = ~w_wr_full & ~drain_i;

  assign w_ar_hs  = slv_req_i.ar_valid & mst_resp_i.ar_ready & w_ar_open;
  assign w_aw_hs  = slv_req_i.aw_valid & mst_resp_i.aw_ready & w_aw_open;
  // A W beat may ride along with the AW that opens its burst.
  assign w_w_open = (r_w_pend != 8'd0) | w_aw_hs;
  assign w_w_hs   = slv_req_i.w_valid & mst_resp_i.w_ready & w_w_open;
  assign w_w_done = w_w_hs & slv_req_i.w.last;
  assign w_r_done = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_done = mst_resp_i.b_valid & slv_req_i.b_ready;

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & w_ar_open;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & w_aw_open;
    mst_req_o.w_valid   = slv_req_i.w_valid & w_w_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_open;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_w_open;
  end

  // Simultaneous increment/decrement cancels; decrements at zero are held (flagged as error).
  always_comb begin
    w_rd_nxt   = r_rd_cnt;
    w_wr_nxt   = r_wr_cnt;
    w_pend_nxt = r_w_pend;
    if (w_ar_hs && !w_r_done)                            w_rd_nxt = r_rd_cnt + 8'd1;
    else if (!w_ar_hs && w_r_done && r_rd_cnt != 8'd0)   w_rd_nxt = r_rd_cnt - 8'd1;
    if (w_aw_hs && !w_b_done)                            w_wr_nxt = r_wr_cnt + 8'd1;
    else if (!w_aw_hs && w_b_done && r_wr_cnt != 8'd0)   w_wr_nxt = r_wr_cnt - 8'd1;
    if (w_aw_hs && !w_w_done)                            w_pend_nxt = r_w_pend + 8'd1;
    else if (!w_aw_hs && w_w_done && r_w_pend != 8'd0)   w_pend_nxt = r_w_pend - 8'd1;
  end

  assign w_err_evt = (w_r_done && r_rd_cnt == 8'd0) |
                     (w_b_done && r_wr_cnt == 8'd0) |
                     (w_w_hs && r_w_pend == 8'd0 && !w_aw_hs);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
      r_w_pend <= 8'd0;
      r_err    <= 1'b0;
      r_idle   <= 1'b1;
    end else if (clr_i) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
      r_w_pend <= 8'd0;
      r_err    <= 1'b0;
      r_idle   <= 1'b1;
    end else begin
      r_rd_cnt <= w_rd_nxt;
      r_wr_cnt <= w_wr_nxt;
      r_w_pend <= w_pend_nxt;
      r_err    <= r_err | w_err_evt;
      r_idle   <= (w_rd_nxt == 8'd0) && (w_wr_nxt == 8'd0) && (w_pend_nxt == 8'd0);
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
  assign err_o    = r_err;
  assign idle_o   = r_idle;

`ifdef CACHE_AXI_LIMITER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (slv_req_i.ar_valid & (w_rd_full | drain_i)) |
                   (slv_req_i.aw_valid & (w_wr_full | drain_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                r_stall_cnt <= 32'd0;
    else if (clr_i)                           r_stall_cnt <= 32'd0;
    else if (w_stall && r_stall_cnt != '1)    r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
